// File: rtl/sram_port_arbiter_if.sv
// Client-side bundle of sram_port_arbiter: scan-out read port and drawer write-push port.
// The arbiter takes the slave view; the scan-out/drawer side takes the master view.
interface sram_port_arbiter_if #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_overflow;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_data, rd_valid, wr_ready, wr_overflow, fifo_level
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_data, rd_valid, wr_ready, wr_overflow, fifo_level
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Time-shares one asynchronous SRAM port: scan-out reads always win; drawer writes are
// buffered in a small FIFO and drained in read-free slots. All SRAM pins are registered.
module sram_port_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [ADDR_W-1:0]   fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic                overflow_r;
    logic [ADDR_W-1:0]   sram_addr_r;
    logic [DATA_W-1:0]   dq_out_r;
    logic                we_n_r;
    logic                oe_n_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_valid_r;
    logic                wr_ready_s;
    logic                push_s;
    logic                pop_s;

    // Slot selection: reads first, then buffered writes, else idle.
    always_comb begin
        next_state_s = ST_IDLE;
        wr_ready_s   = (level_r < DEPTH_L);
        push_s       = bus.wr_req && wr_ready_s;
        if (bus.rd_req) begin
            next_state_s = ST_READ;
        end else if (level_r != {LVL_W{1'b0}}) begin
            next_state_s = ST_WRITE;
        end else begin
            next_state_s = ST_IDLE;
        end
        pop_s = (next_state_s == ST_WRITE);
    end

    // Slot register and registered SRAM pin drivers for the upcoming slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sram_addr_r <= {ADDR_W{1'b0}};
            dq_out_r    <= {DATA_W{1'b0}};
            we_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
        end else begin
            state_r <= next_state_s;
            case (next_state_s)
                ST_READ: begin
                    sram_addr_r <= bus.rd_addr;
                    oe_n_r      <= 1'b0;
                    we_n_r      <= 1'b1;
                end
                ST_WRITE: begin
                    sram_addr_r <= fifo_addr_r[rd_ptr_r];
                    dq_out_r    <= fifo_data_r[rd_ptr_r];
                    oe_n_r      <= 1'b1;
                    we_n_r      <= 1'b0;
                end
                default: begin
                    oe_n_r <= 1'b1;
                    we_n_r <= 1'b1;
                end
            endcase
        end
    end

    // Capture the bus at the end of a read slot; rd_data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (state_r == ST_READ) begin
            rd_data_r  <= sram_dq;
            rd_valid_r <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    // Write FIFO; the full check uses the registered level, so a pop never frees room early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i] <= {ADDR_W{1'b0}};
                fifo_data_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= bus.wr_addr;
                fifo_data_r[wr_ptr_r] <= bus.wr_data;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
            if (bus.wr_req && !wr_ready_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign sram_addr       = sram_addr_r;
    assign sram_we_n       = we_n_r;
    assign sram_oe_n       = oe_n_r;
    assign sram_ce_n       = 1'b0;
    assign sram_ub_n       = 1'b0;
    assign sram_lb_n       = 1'b0;
    assign sram_dq         = (state_r == ST_WRITE) ? dq_out_r : {DATA_W{1'bz}};
    assign bus.rd_data     = rd_data_r;
    assign bus.rd_valid    = rd_valid_r;
    assign bus.wr_ready    = wr_ready_s;
    assign bus.wr_overflow = overflow_r;
    assign bus.fifo_level  = level_r;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized scoreboard bench for sram_port_arbiter: a queue-level model predicts every
// read response, write slot and FIFO status; a negedge monitor compares against the DUT.
module tb_sram_port_arbiter;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

    wire  [DATA_W-1:0] sram_dq;
    logic [ADDR_W-1:0] sram_addr;
    logic sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // Asynchronous SRAM model: unwritten words read back as addr[15:0].
    bit   [15:0] mem     [0:(1<<ADDR_W)-1];
    bit          written [0:(1<<ADDR_W)-1];
    logic [15:0] sram_rd_s;
    assign sram_rd_s = written[sram_addr] ? mem[sram_addr] : sram_addr[15:0];
    assign sram_dq   = (!sram_oe_n && sram_we_n) ? sram_rd_s : 16'bz;
    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr]     <= sram_dq;
            written[sram_addr] <= 1'b1;
        end
    end

    function automatic logic [15:0] sram_peek(input logic [17:0] a);
        return written[a] ? mem[a] : a[15:0];
    endfunction

    // Reference model state.
    typedef struct { logic [17:0] a; logic [15:0] d; } wr_t;
    typedef struct { logic [15:0] d; int c; } rexp_t;
    typedef struct { logic [17:0] a; logic [15:0] d; int c; } wexp_t;
    wr_t         mq[$];
    rexp_t       exp_rd[$];
    wexp_t       exp_wr[$];
    logic [15:0] ref_mem [logic [17:0]];
    bit          m_ovf  = 1'b0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock of stimulus; the model applies the arbitration rules at the same edge.
    task automatic step(input bit r, input logic [17:0] ra, input bit w,
                        input logic [17:0] wa, input logic [15:0] wd);
        bit    acc;
        wr_t   e;
        bus.rd_req  = r;
        bus.rd_addr = ra;
        bus.wr_req  = w;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        @(posedge clk);
        cyc++;
        acc = w && (mq.size() < DEPTH);
        if (r) begin
            exp_rd.push_back('{ref_rd(ra), cyc});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            ref_mem[e.a] = e.d;
            exp_wr.push_back('{e.a, e.d, cyc});
        end
        if (acc) mq.push_back('{wa, wd});
        else if (w) m_ovf = 1'b1;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 18'h0, 1'b0, 18'h0, 16'h0);
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    rexp_t re;
    wexp_t we;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("oe_we_both_low", {31'd0, (!sram_oe_n && !sram_we_n)}, 32'd0);
            chk("fifo_level", {29'd0, bus.fifo_level}, mq.size());
            chk("wr_ready", {31'd0, bus.wr_ready}, {31'd0, (mq.size() < DEPTH)});
            chk("wr_overflow", {31'd0, bus.wr_overflow}, {31'd0, m_ovf});
            if (bus.rd_valid) begin
                chk("rd_pending", {31'd0, (exp_rd.size() != 0)}, 32'd1);
                if (exp_rd.size() != 0) begin
                    re = exp_rd.pop_front();
                    chk("rd_data", {16'd0, bus.rd_data}, {16'd0, re.d});
                    chk("rd_latency", cyc, re.c + 1);
                end
            end else if (exp_rd.size() != 0 && exp_rd[0].c + 1 <= cyc) begin
                chk("rd_valid", {31'd0, bus.rd_valid}, 32'd1);
                void'(exp_rd.pop_front());
            end
            if (!sram_we_n) begin
                chk("wr_pending", {31'd0, (exp_wr.size() != 0)}, 32'd1);
                if (exp_wr.size() != 0) begin
                    we = exp_wr.pop_front();
                    chk("wr_addr", {14'd0, sram_addr}, {14'd0, we.a});
                    chk("wr_data", {16'd0, sram_dq}, {16'd0, we.d});
                    chk("wr_slot_cycle", cyc, we.c);
                end
            end else if (exp_wr.size() != 0 && exp_wr[0].c <= cyc) begin
                chk("sram_we_n", {31'd0, sram_we_n}, 32'd0);
                void'(exp_wr.pop_front());
            end
        end
    end

    initial begin
        bus.rd_req = 1'b0; bus.rd_addr = 18'h0;
        bus.wr_req = 1'b0; bus.wr_addr = 18'h0; bus.wr_data = 16'h0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_ce_ub_lb", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
        chk("rst_overflow", {31'd0, bus.wr_overflow}, 32'd0);
        chk("rst_level", {29'd0, bus.fifo_level}, 32'd0);
        mon_en = 1'b1;

        // Reset asserted in the middle of a write slot.
        step(1'b0, 18'h0, 1'b1, 18'h00200, 16'hBEEF);
        step(1'b0, 18'h0, 1'b0, 18'h0, 16'h0);
        #1 chk("we_n_mid_write", {31'd0, sram_we_n}, 32'd0);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("async_rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("async_rst_level", {29'd0, bus.fifo_level}, 32'd0);
        chk("async_rst_addr", {14'd0, sram_addr}, 32'd0);
        mq.delete(); exp_rd.delete(); exp_wr.delete(); ref_mem.delete(); m_ovf = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        chk("aborted_write_absent", {31'd0, written[18'h00200]}, 32'd0);

        // Read stream of 8 consecutive requests.
        for (int i = 0; i < 8; i++) step(1'b1, 18'h00010 + 18'(i), 1'b0, 18'h0, 16'h0);
        idle(3);

        // Write drain with no reads.
        step(1'b0, 18'h0, 1'b1, 18'h00100, 16'hAAAA);
        step(1'b0, 18'h0, 1'b1, 18'h00101, 16'h5555);
        step(1'b0, 18'h0, 1'b1, 18'h00102, 16'h1234);
        idle(4);
        chk("mem_100", {16'd0, sram_peek(18'h00100)}, 32'h0000AAAA);
        chk("mem_101", {16'd0, sram_peek(18'h00101)}, 32'h00005555);
        chk("mem_102", {16'd0, sram_peek(18'h00102)}, 32'h00001234);

        // Arbitration: two buffered writes against a 1,0,1,0 read pattern.
        step(1'b1, 18'h00020, 1'b1, 18'h00300, 16'h1111);
        step(1'b1, 18'h00021, 1'b1, 18'h00301, 16'h2222);
        step(1'b1, 18'h00022, 1'b0, 18'h0, 16'h0);
        step(1'b0, 18'h0,     1'b0, 18'h0, 16'h0);
        step(1'b1, 18'h00023, 1'b0, 18'h0, 16'h0);
        step(1'b0, 18'h0,     1'b0, 18'h0, 16'h0);
        idle(2);

        // Full and overflow under continuous reads, then release.
        for (int i = 0; i < 5; i++)
            step(1'b1, 18'h00030 + 18'(i), 1'b1, 18'h00400 + 18'(i), 16'hC000 + 16'(i));
        idle(6);
        chk("dropped_push_absent", {31'd0, written[18'h00404]}, 32'd0);
        chk("mem_403", {16'd0, sram_peek(18'h00403)}, 32'h0000C003);

        // Simultaneous push and pop at level 2.
        step(1'b1, 18'h00040, 1'b1, 18'h00500, 16'hD000);
        step(1'b1, 18'h00041, 1'b1, 18'h00501, 16'hD001);
        step(1'b0, 18'h0,     1'b1, 18'h00502, 16'hD002);
        idle(4);

        // Random traffic over a small address window so reads hit recent writes.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), 18'($urandom_range(0, 31)),
                 ($urandom_range(0, 1) == 1), 18'($urandom_range(0, 31)), 16'($urandom));
        end
        idle(8);

        chk("rd_queue_drained", exp_rd.size(), 32'd0);
        chk("wr_queue_drained", exp_wr.size(), 32'd0);
        foreach (ref_mem[k]) chk("mem_final", {16'd0, sram_peek(k)}, {16'd0, ref_mem[k]});

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
